// File: rtl/pipeline_ctrl.sv
// Hazard controller for a 5-stage pipeline: stalls, flushes, forwarding and a data-memory wait FSM.
// Compile-time option PIPELINE_CTRL_FORWARDING_EN selects forwarding; without it RAW hazards stall.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [4:0]  RsE,
  input  logic [4:0]  RtE,
  input  logic [4:0]  WriteRegE,
  input  logic [4:0]  WriteRegM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemtoRegE,
  input  logic        MemtoRegM,
  input  logic        BranchD,
  input  logic        PCSrcD,
  input  logic        MemAccessM,
  input  logic        MemReadyM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        ForwardAD,
  output logic        ForwardBD,
  output logic        MemReqM,
  output logic        MemTimeout,
  output logic [15:0] StallCount
);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } mem_state_e;

  mem_state_e  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic mem_stall;
  logic lw_stall;
  logic branch_stall;
  logic raw_stall;
  logic dec_stall;

  // A non-zero destination that one of the Decode sources reads.
  function automatic logic dst_hits_d(input logic en, input logic [4:0] dst,
                                      input logic [4:0] rs, input logic [4:0] rt);
    return en && (dst != 5'd0) && ((dst == rs) || (dst == rt));
  endfunction

`ifdef PIPELINE_CTRL_FORWARDING_EN
  function automatic logic [1:0] fwd_sel_e(input logic [4:0] src, input logic rw_m,
                                           input logic [4:0] dst_m, input logic rw_w,
                                           input logic [4:0] dst_w);
    if (src != 5'd0 && rw_m && dst_m == src)      return 2'b10;
    else if (src != 5'd0 && rw_w && dst_w == src) return 2'b01;
    else                                          return 2'b00;
  endfunction
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{RsE, RtE, WriteRegW, RegWriteW};
`endif

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    raw_stall = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
`ifdef PIPELINE_CTRL_FORWARDING_EN
    if (!rst) begin
      ForwardAE = fwd_sel_e(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
      ForwardBE = fwd_sel_e(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
      ForwardAD = (RsD != 5'd0) && RegWriteM && (WriteRegM == RsD);
      ForwardBD = (RtD != 5'd0) && RegWriteM && (WriteRegM == RtD);
    end
`else
    raw_stall = dst_hits_d(RegWriteE, WriteRegE, RsD, RtD) ||
                dst_hits_d(RegWriteM, WriteRegM, RsD, RtD);
`endif

    mem_stall = !rst && (((state_q == ST_IDLE) && MemAccessM && !MemReadyM) ||
                         ((state_q == ST_WAIT) && !MemReadyM));
    lw_stall     = dst_hits_d(MemtoRegE, WriteRegE, RsD, RtD) || raw_stall;
    branch_stall = BranchD && (dst_hits_d(RegWriteE, WriteRegE, RsD, RtD) ||
                               dst_hits_d(MemtoRegM, WriteRegM, RsD, RtD));
    dec_stall    = !rst && (lw_stall || branch_stall);

    // Memory stall freezes the whole front of the pipe and bubbles Writeback; it overrides Decode hazards.
    StallF  = mem_stall || dec_stall;
    StallD  = mem_stall || dec_stall;
    StallE  = mem_stall;
    StallM  = mem_stall;
    FlushW  = mem_stall;
    FlushE  = !mem_stall && dec_stall;
    FlushD  = !rst && PCSrcD && !StallD;
    MemReqM = !rst && ((state_q == ST_WAIT) || MemAccessM);
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (MemAccessM && !MemReadyM) begin
          state_d    = ST_WAIT;
          wait_cnt_d = 8'd0;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
        if (MemReadyM) begin
          state_d = ST_IDLE;
        end else if (wait_cnt_d == 8'hFF) begin
          // Timed-out accesses keep waiting; only the sticky flag records it.
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (StallF && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign MemTimeout = timeout_q;
  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl; expectations follow PIPELINE_CTRL_FORWARDING_EN.
module tb_pipeline_ctrl;

`ifdef PIPELINE_CTRL_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic        BranchD, PCSrcD, MemAccessM, MemReadyM;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        ForwardAD, ForwardBD, MemReqM, MemTimeout;
  logic [15:0] StallCount;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_cycles;
  int req_cycles;

  pipeline_ctrl dut (
    .clk(clk), .rst(rst),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .PCSrcD(PCSrcD),
    .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .MemReqM(MemReqM), .MemTimeout(MemTimeout), .StallCount(StallCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    RsD = 5'd0; RtD = 5'd0; RsE = 5'd0; RtE = 5'd0;
    WriteRegE = 5'd0; WriteRegM = 5'd0; WriteRegW = 5'd0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b0; MemtoRegM = 1'b0;
    BranchD = 1'b0; PCSrcD = 1'b0; MemAccessM = 1'b0; MemReadyM = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    // Hazards present during reset must not reach the outputs.
    MemAccessM = 1'b1; PCSrcD = 1'b1; MemtoRegE = 1'b1; WriteRegE = 5'd9; RtD = 5'd9;
    RegWriteM = 1'b1; WriteRegM = 5'd8; RsE = 5'd8;
    #2;
    check("rst_stallf",  32'(StallF), 0);
    check("rst_stallm",  32'(StallM), 0);
    check("rst_flushd",  32'(FlushD), 0);
    check("rst_flushe",  32'(FlushE), 0);
    check("rst_flushw",  32'(FlushW), 0);
    check("rst_memreq",  32'(MemReqM), 0);
    check("rst_fwdae",   32'(ForwardAE), 0);
    next_cycle();
    check("rst_stallcnt", 32'(StallCount), 0);
    check("rst_timeout",  32'(MemTimeout), 0);
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    check("idle_stallf", 32'(StallF), 0);
    check("idle_memreq", 32'(MemReqM), 0);

    // Execute forwarding: M beats W, register 0 never forwards.
    next_cycle();
    RegWriteM = 1'b1; WriteRegM = 5'd8; RegWriteW = 1'b1; WriteRegW = 5'd8; RsE = 5'd8; RtE = 5'd8;
    @(negedge clk);
    check("fwd_ae_m",  32'(ForwardAE), FWD ? 2 : 0);
    check("fwd_be_m",  32'(ForwardBE), FWD ? 2 : 0);
    RsE = 5'd0;
    #1;
    check("fwd_ae_r0", 32'(ForwardAE), 0);
    check("fwd_be_m2", 32'(ForwardBE), FWD ? 2 : 0);
    RegWriteM = 1'b0; RsE = 5'd8;
    #1;
    check("fwd_ae_w",  32'(ForwardAE), FWD ? 1 : 0);
    check("fwd_nostall", 32'(StallF), 0);

    // Load-use hazard: one stall cycle counted.
    next_cycle();
    clear_inputs();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd9; RtD = 5'd9;
    @(negedge clk);
    check("lu_stallf", 32'(StallF), 1);
    check("lu_stalld", 32'(StallD), 1);
    check("lu_flushe", 32'(FlushE), 1);
    check("lu_stalle", 32'(StallE), 0);
    check("lu_stallm", 32'(StallM), 0);
    check("lu_flushw", 32'(FlushW), 0);
    check("lu_cnt0",   32'(StallCount), 0);
    next_cycle();
    clear_inputs();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd0; RsD = 5'd0;
    @(negedge clk);
    check("lu_cnt1",   32'(StallCount), 1);
    check("lu_r0_nostall", 32'(StallF), 0);

    // Decode-side RAW on M: forwarded when enabled, stalled otherwise.
    next_cycle();
    clear_inputs();
    RegWriteM = 1'b1; WriteRegM = 5'd8; RsD = 5'd8; RtD = 5'd3;
    @(negedge clk);
    check("raw_fwdad", 32'(ForwardAD), FWD ? 1 : 0);
    check("raw_fwdbd", 32'(ForwardBD), 0);
    check("raw_stallf", 32'(StallF), FWD ? 0 : 1);
    check("raw_flushe", 32'(FlushE), FWD ? 0 : 1);

    // Branch taken without and with a hazard.
    next_cycle();
    clear_inputs();
    BranchD = 1'b1; PCSrcD = 1'b1; RsD = 5'd4; RtD = 5'd5;
    @(negedge clk);
    check("br_flushd",  32'(FlushD), 1);
    check("br_stalld",  32'(StallD), 0);
    next_cycle();
    RegWriteE = 1'b1; WriteRegE = 5'd5;
    @(negedge clk);
    check("brh_flushd", 32'(FlushD), 0);
    check("brh_stalld", 32'(StallD), 1);
    check("brh_flushe", 32'(FlushE), 1);
    next_cycle();
    clear_inputs();
    BranchD = 1'b1; RsD = 5'd4; MemtoRegM = 1'b1; WriteRegM = 5'd4;
    @(negedge clk);
    check("brm_stalld", 32'(StallD), 1);

    // Memory wait of 3 cycles, with a load-use hazard and taken branch underneath.
    next_cycle();
    clear_inputs();
    MemAccessM = 1'b1; MemReadyM = 1'b0;
    MemtoRegE = 1'b1; WriteRegE = 5'd9; RtD = 5'd9; PCSrcD = 1'b1;
    stall_cycles = 0;
    req_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) MemReadyM = 1'b1;
      @(negedge clk);
      if (i == 0) begin
        check("mw_prio_flushe", 32'(FlushE), 0);
        check("mw_prio_flushd", 32'(FlushD), 0);
        check("mw_prio_stalle", 32'(StallE), 1);
      end
      if (StallF && StallD && StallE && StallM && FlushW) stall_cycles++;
      if (MemReqM) req_cycles++;
      next_cycle();
    end
    clear_inputs();
    @(negedge clk);
    check("mw_stall_cycles", 32'(stall_cycles), 3);
    check("mw_req_cycles",   32'(req_cycles), 4);
    check("mw_idle_req",     32'(MemReqM), 0);
    check("mw_idle_stallm",  32'(StallM), 0);

    // Timeout: sticky after 255 WAIT cycles, FSM keeps waiting.
    next_cycle();
    MemAccessM = 1'b1; MemReadyM = 1'b0;
    next_cycle();
    MemAccessM = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check("to_early",     32'(MemTimeout), 0);
    check("to_wait_req",  32'(MemReqM), 1);
    repeat (60) @(posedge clk);
    #1;
    check("to_set",       32'(MemTimeout), 1);
    check("to_still_stall", 32'(StallM), 1);
    MemReadyM = 1'b1;
    next_cycle();
    MemReadyM = 1'b0;
    repeat (3) next_cycle();
    check("to_sticky",    32'(MemTimeout), 1);
    check("to_idle_req",  32'(MemReqM), 0);

    // Reset mid-wait aborts the access asynchronously.
    MemAccessM = 1'b1;
    next_cycle();
    MemAccessM = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    check("rw_pre_stallm", 32'(StallM), 1);
    #2;
    rst = 1'b1;
    #1;
    check("rw_memreq",   32'(MemReqM), 0);
    check("rw_stallm",   32'(StallM), 0);
    check("rw_stallcnt", 32'(StallCount), 0);
    check("rw_timeout",  32'(MemTimeout), 0);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    MemAccessM = 1'b1; MemReadyM = 1'b1;
    @(negedge clk);
    check("rw_new_stallf", 32'(StallF), 0);
    check("rw_new_req",    32'(MemReqM), 1);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    check("rw_new_idle",   32'(MemReqM), 0);
    check("rw_new_cnt",    32'(StallCount), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
